// File: rtl/regfile_dbg_pkg.sv
// regfile_dbg_pkg: shared defaults and FSM encoding for the regfile dump block.
// Imported by the dump controller, its port mux and its handshake interface.
package regfile_dbg_pkg;

    localparam int DEF_NB_DATA = 32;
    localparam int DEF_NB_ADDR = 5;
    localparam int DEF_N_REGS  = 32;

    typedef enum logic [2:0] {
        IDLE,
        HALT_WAIT,
        READ,
        SEND,
        DONE
    } state_t;

endpackage

// File: rtl/regfile_dump_ctrl_if.sv
// regfile_dump_ctrl_if: valid/ready word stream from the dump controller
// (master) to the debug unit (slave).
interface regfile_dump_ctrl_if
    import regfile_dbg_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_ADDR = DEF_NB_ADDR
);

    logic               dump_valid;
    logic               dump_ready;
    logic [NB_DATA-1:0] dump_data;
    logic [NB_ADDR-1:0] dump_idx;
    logic               dump_last;

    modport master (
        output dump_valid,
        output dump_data,
        output dump_idx,
        output dump_last,
        input  dump_ready
    );

    modport slave (
        input  dump_valid,
        input  dump_data,
        input  dump_idx,
        input  dump_last,
        output dump_ready
    );

endinterface

// File: rtl/regfile_port_mux.sv
// regfile_port_mux: combinational steering of the rf rs/rt read addresses
// and the write port (optional debug poke under REGFILE_DBG_POKE_EN).
module regfile_port_mux
    import regfile_dbg_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_ADDR = DEF_NB_ADDR
) (
    input  logic               sel_dump,
    input  logic [NB_ADDR-1:0] idx,
    input  logic [NB_ADDR-1:0] pipe_rs_addr,
    input  logic [NB_ADDR-1:0] pipe_rt_addr,
    input  logic               pipe_we,
    input  logic [NB_ADDR-1:0] pipe_rd_addr,
    input  logic [NB_DATA-1:0] pipe_rd_data,
`ifdef REGFILE_DBG_POKE_EN
    input  logic               poke_sel,
    input  logic [NB_ADDR-1:0] poke_addr,
    input  logic [NB_DATA-1:0] poke_data,
`endif
    output logic [NB_ADDR-1:0] rf_addres_rs,
    output logic [NB_ADDR-1:0] rf_addres_rt,
    output logic               rf_w_enable,
    output logic [NB_ADDR-1:0] rf_addres_rd,
    output logic [NB_DATA-1:0] rf_data_rd
);

    always_comb begin
        rf_addres_rs = sel_dump ? idx : pipe_rs_addr;
        rf_addres_rt = pipe_rt_addr;
        rf_w_enable  = pipe_we;
        rf_addres_rd = pipe_rd_addr;
        rf_data_rd   = pipe_rd_data;
`ifdef REGFILE_DBG_POKE_EN
        // poke_sel already excludes pipe_we, so writeback is never displaced
        if (poke_sel) begin
            rf_w_enable  = 1'b1;
            rf_addres_rd = poke_addr;
            rf_data_rd   = poke_data;
        end
`endif
    end

endmodule

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: freezes the pipeline and streams every register to the
// debug unit. Optional debug write port: define REGFILE_DBG_POKE_EN.
module regfile_dump_ctrl
    import regfile_dbg_pkg::*;
#(
    parameter int NB_DATA = DEF_NB_DATA,
    parameter int NB_ADDR = DEF_NB_ADDR,
    parameter int N_REGS  = DEF_N_REGS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dump_start,
    input  logic               halted,
    output logic               halt_req,
    input  logic [NB_ADDR-1:0] pipe_rs_addr,
    input  logic [NB_ADDR-1:0] pipe_rt_addr,
    input  logic               pipe_we,
    input  logic [NB_ADDR-1:0] pipe_rd_addr,
    input  logic [NB_DATA-1:0] pipe_rd_data,
    output logic [NB_ADDR-1:0] rf_addres_rs,
    output logic [NB_ADDR-1:0] rf_addres_rt,
    output logic               rf_w_enable,
    output logic [NB_ADDR-1:0] rf_addres_rd,
    output logic [NB_DATA-1:0] rf_data_rd,
    input  logic [NB_DATA-1:0] rf_data_rs,
    regfile_dump_ctrl_if.master dump,
    output logic               busy,
    output logic               dump_done
`ifdef REGFILE_DBG_POKE_EN
    ,
    input  logic               poke_valid,
    input  logic [NB_ADDR-1:0] poke_addr,
    input  logic [NB_DATA-1:0] poke_data,
    output logic               poke_ready
`endif
);

    localparam logic [NB_ADDR-1:0] LAST_IDX = NB_ADDR'(N_REGS - 1);

    state_t             state_q, state_d;
    logic [NB_ADDR-1:0] idx_q, idx_d;
    logic [NB_DATA-1:0] data_q, data_d;
    logic [NB_ADDR-1:0] didx_q, didx_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            didx_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            didx_q  <= didx_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        didx_d  = didx_q;
        valid_d = valid_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (dump_start) state_d = HALT_WAIT;
            end
            HALT_WAIT: begin
                if (halted) state_d = READ;
            end
            READ: begin
                // a lost freeze skips the capture and re-reads the same idx
                if (!halted) begin
                    state_d = HALT_WAIT;
                end else begin
                    data_d  = rf_data_rs;
                    didx_d  = idx_q;
                    valid_d = 1'b1;
                    last_d  = (idx_q == LAST_IDX);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (dump.dump_ready) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                last_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        halt_req  = (state_q == HALT_WAIT) || (state_q == READ) ||
                    (state_q == SEND);
        busy      = (state_q != IDLE);
        dump_done = (state_q == DONE);
    end

    assign dump.dump_valid = valid_q;
    assign dump.dump_data  = data_q;
    assign dump.dump_idx   = didx_q;
    assign dump.dump_last  = last_q;

`ifdef REGFILE_DBG_POKE_EN
    logic poke_sel;

    assign poke_ready = halt_req && halted && !pipe_we;
    assign poke_sel   = poke_valid && poke_ready;
`endif

    regfile_port_mux #(
        .NB_DATA(NB_DATA),
        .NB_ADDR(NB_ADDR)
    ) u_mux (
        .sel_dump    (state_q == READ),
        .idx         (idx_q),
        .pipe_rs_addr(pipe_rs_addr),
        .pipe_rt_addr(pipe_rt_addr),
        .pipe_we     (pipe_we),
        .pipe_rd_addr(pipe_rd_addr),
        .pipe_rd_data(pipe_rd_data),
`ifdef REGFILE_DBG_POKE_EN
        .poke_sel    (poke_sel),
        .poke_addr   (poke_addr),
        .poke_data   (poke_data),
`endif
        .rf_addres_rs(rf_addres_rs),
        .rf_addres_rt(rf_addres_rt),
        .rf_w_enable (rf_w_enable),
        .rf_addres_rd(rf_addres_rd),
        .rf_data_rd  (rf_data_rd)
    );

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: drives random dumps against a regfile model and
// compares each streamed word with the bench's own register snapshot.
module tb_regfile_dump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        dump_start;
    logic        halted;
    logic        halt_req;
    logic [4:0]  pipe_rs_addr;
    logic [4:0]  pipe_rt_addr;
    logic        pipe_we;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_rd_data;
    logic [4:0]  rf_addres_rs;
    logic [4:0]  rf_addres_rt;
    logic        rf_w_enable;
    logic [4:0]  rf_addres_rd;
    logic [31:0] rf_data_rd;
    logic [31:0] rf_data_rs;
    logic        busy;
    logic        dump_done;
`ifdef REGFILE_DBG_POKE_EN
    logic        poke_valid;
    logic [4:0]  poke_addr;
    logic [31:0] poke_data;
    logic        poke_ready;
`endif

    regfile_dump_ctrl_if #(.NB_DATA(32), .NB_ADDR(5)) dif ();

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] gold [32];
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    // register file: write at the edge, combinational read with forwarding
    always @(posedge clk) begin
        if (rf_w_enable) rf[rf_addres_rd] <= rf_data_rd;
    end
    assign rf_data_rs = (rf_w_enable && rf_addres_rd == rf_addres_rs) ?
                        rf_data_rd : rf[rf_addres_rs];

    regfile_dump_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .dump_start  (dump_start),
        .halted      (halted),
        .halt_req    (halt_req),
        .pipe_rs_addr(pipe_rs_addr),
        .pipe_rt_addr(pipe_rt_addr),
        .pipe_we     (pipe_we),
        .pipe_rd_addr(pipe_rd_addr),
        .pipe_rd_data(pipe_rd_data),
        .rf_addres_rs(rf_addres_rs),
        .rf_addres_rt(rf_addres_rt),
        .rf_w_enable (rf_w_enable),
        .rf_addres_rd(rf_addres_rd),
        .rf_data_rd  (rf_data_rd),
        .rf_data_rs  (rf_data_rs),
        .dump        (dif.master),
        .busy        (busy),
        .dump_done   (dump_done)
`ifdef REGFILE_DBG_POKE_EN
        ,
        .poke_valid  (poke_valid),
        .poke_addr   (poke_addr),
        .poke_data   (poke_data),
        .poke_ready  (poke_ready)
`endif
    );

    task automatic check_zero(input string tag);
        n_chk++;
        if (halt_req !== 1'b0 || busy !== 1'b0 || dump_done !== 1'b0 ||
            dif.dump_valid !== 1'b0 || dif.dump_last !== 1'b0 ||
            dif.dump_data !== 32'h0 || dif.dump_idx !== 5'h0) begin
            n_fail++;
            $display("FAIL %s: hr=%b busy=%b done=%b v=%b last=%b d=%h i=%0d, required all 0",
                     tag, halt_req, busy, dump_done, dif.dump_valid,
                     dif.dump_last, dif.dump_data, dif.dump_idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dump_start = 1'b0;
        halted = 1'b0;
        pipe_we = 1'b0;
        pipe_rs_addr = 5'd3;
        pipe_rt_addr = 5'd4;
        pipe_rd_addr = 5'd0;
        pipe_rd_data = 32'h0;
        dif.dump_ready = 1'b0;
`ifdef REGFILE_DBG_POKE_EN
        poke_valid = 1'b0;
        poke_addr = 5'd0;
        poke_data = 32'h0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        n_chk++;
        if (rf_addres_rs !== 5'd3 || rf_addres_rt !== 5'd4) begin
            n_fail++;
            $display("FAIL reset_passthru: rs=%0d rt=%0d, required 3 4",
                     rf_addres_rs, rf_addres_rt);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_preload_passthru();
        logic [31:0] d;
        for (int i = 0; i < 32; i++) begin
            d = $urandom;
            if (i == 1) d = 32'hFF010011;
            if (i == 3) d = 32'hFF010000;
            pipe_we = 1'b1;
            pipe_rd_addr = 5'(i);
            pipe_rd_data = d;
            pipe_rs_addr = 5'($urandom_range(0, 31));
            pipe_rt_addr = 5'($urandom_range(0, 31));
            gold[i] = d;
            #1;
            n_chk++;
            if (rf_w_enable !== 1'b1 || rf_addres_rd !== 5'(i) ||
                rf_data_rd !== d || rf_addres_rs !== pipe_rs_addr ||
                rf_addres_rt !== pipe_rt_addr) begin
                n_fail++;
                $display("FAIL idle_passthru: we=%b rd=%0d data=%h rs=%0d rt=%0d, required 1 %0d %h %0d %0d",
                         rf_w_enable, rf_addres_rd, rf_data_rd, rf_addres_rs,
                         rf_addres_rt, i, d, pipe_rs_addr, pipe_rt_addr);
            end
            @(posedge clk);
            #1;
        end
        pipe_we = 1'b0;
    endtask

    // rmode: 0 ready always, 1 ready 1-of-3 cycles, 2 random ready
    task automatic run_dump(input int rmode, input int hdelay, input int drop_idx,
                            input int abort_idx, input bit extras);
        int nxt, drop_cnt, last_idx, done_cyc;
        bit acc, prev_acc, stall, done_seen, dropped;
        logic [31:0] sd;
        logic [4:0] si;
        nxt = 0; drop_cnt = 0; last_idx = -9; done_cyc = -1;
        acc = 0; stall = 0; done_seen = 0; dropped = 0;
        sd = '0; si = '0;
        halted = 1'b0;
        dif.dump_ready = 1'b0;
        dump_start = 1'b1;
        @(posedge clk);
        #1;
        dump_start = 1'b0;
        n_chk++;
        if (halt_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_halt_req: halt_req=%b busy=%b, required 1 1",
                     halt_req, busy);
        end
        for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
            prev_acc = acc;
            pipe_we = 1'b0;
            dump_start = 1'b0;
`ifdef REGFILE_DBG_POKE_EN
            poke_valid = 1'b0;
`endif
            if (prev_acc && last_idx == drop_idx - 1 && !dropped) begin
                halted = 1'b0;
                drop_cnt = 4;
                dropped = 1;
            end else if (drop_cnt > 0) begin
                n_chk++;
                if (halt_req !== 1'b1 || dif.dump_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL halt_drop_hold: halt_req=%b valid=%b, required 1 0",
                             halt_req, dif.dump_valid);
                end
                drop_cnt--;
                halted = (drop_cnt == 0);
            end else if (cyc >= hdelay) begin
                halted = 1'b1;
            end
            if (extras && prev_acc && last_idx == 6) begin
                pipe_we = 1'b1;
                pipe_rd_addr = 5'd7;
                pipe_rd_data = 32'hA5A5A5A5;
                gold[7] = 32'hA5A5A5A5;
                #1;
                n_chk++;
                if (rf_addres_rs !== 5'd7 || rf_w_enable !== 1'b1 ||
                    rf_addres_rd !== 5'd7 || rf_data_rd !== 32'hA5A5A5A5) begin
                    n_fail++;
                    $display("FAIL read_write_7: rs=%0d we=%b rd=%0d data=%h, required 7 1 7 a5a5a5a5",
                             rf_addres_rs, rf_w_enable, rf_addres_rd, rf_data_rd);
                end
            end
            if (extras && prev_acc && last_idx == 12) dump_start = 1'b1;
`ifdef REGFILE_DBG_POKE_EN
            if (extras && prev_acc && last_idx == 0) begin
                poke_valid = 1'b1;
                poke_addr = 5'd9;
                poke_data = 32'h12345678;
                gold[9] = 32'h12345678;
                #1;
                n_chk++;
                if (poke_ready !== 1'b1 || rf_w_enable !== 1'b1 ||
                    rf_addres_rd !== 5'd9 || rf_data_rd !== 32'h12345678) begin
                    n_fail++;
                    $display("FAIL poke_ok: ready=%b we=%b rd=%0d data=%h, required 1 1 9 12345678",
                             poke_ready, rf_w_enable, rf_addres_rd, rf_data_rd);
                end
            end
            if (extras && prev_acc && last_idx == 1) begin
                pipe_we = 1'b1;
                pipe_rd_addr = 5'd10;
                pipe_rd_data = 32'h0BADF00D;
                poke_valid = 1'b1;
                poke_addr = 5'd10;
                poke_data = 32'h12345678;
                gold[10] = 32'h0BADF00D;
                #1;
                n_chk++;
                if (poke_ready !== 1'b0 || rf_data_rd !== 32'h0BADF00D) begin
                    n_fail++;
                    $display("FAIL poke_vs_pipe: ready=%b data=%h, required 0 0badf00d",
                             poke_ready, rf_data_rd);
                end
            end
`endif
            if (dump_done === 1'b1) begin
                done_seen = 1;
                done_cyc = cyc;
                n_chk++;
                if (nxt != 32 || halt_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_pulse: words=%0d halt_req=%b, required 32 0",
                             nxt, halt_req);
                end
            end
            if (stall) begin
                n_chk++;
                if (dif.dump_valid !== 1'b1 || dif.dump_data !== sd ||
                    dif.dump_idx !== si) begin
                    n_fail++;
                    $display("FAIL stall_stable: v=%b d=%h i=%0d, required 1 %h %0d",
                             dif.dump_valid, dif.dump_data, dif.dump_idx, sd, si);
                end
            end
            if (abort_idx >= 0 && dif.dump_valid === 1'b1 &&
                dif.dump_idx == 5'(abort_idx)) begin
                dif.dump_ready = 1'b0;
                rst = 1'b1;
                #1;
                check_zero("async_reset_mid_dump");
                return;
            end
            case (rmode)
                0: dif.dump_ready = 1'b1;
                1: dif.dump_ready = (cyc % 3 == 0);
                default: dif.dump_ready = 1'($urandom_range(0, 1));
            endcase
            acc = (dif.dump_valid === 1'b1) && dif.dump_ready;
            stall = (dif.dump_valid === 1'b1) && !dif.dump_ready;
            sd = dif.dump_data;
            si = dif.dump_idx;
            if (acc) begin
                n_chk++;
                if (nxt > 31 || dif.dump_idx !== 5'(nxt) ||
                    dif.dump_data !== gold[nxt[4:0]] ||
                    dif.dump_last !== (nxt == 31)) begin
                    n_fail++;
                    $display("FAIL word: idx=%0d data=%h last=%b, required %0d %h %b",
                             dif.dump_idx, dif.dump_data, dif.dump_last,
                             nxt, gold[nxt[4:0]], (nxt == 31));
                end
                last_idx = int'(dif.dump_idx);
                nxt++;
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (!done_seen) begin
            n_fail++;
            $display("FAIL dump_timeout: words=%0d, required 32 and a done pulse", nxt);
        end
        if (done_seen && rmode == 0 && drop_idx < 0 && !extras) begin
            n_chk++;
            if (done_cyc != hdelay + 65) begin
                n_fail++;
                $display("FAIL dump_latency: done at %0d, required %0d",
                         done_cyc, hdelay + 65);
            end
        end
        n_chk++;
        if (dump_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_one_cycle: done=%b busy=%b, required 0 0",
                     dump_done, busy);
        end
        halted = 1'b0;
        dif.dump_ready = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_dump();
        run_dump(0, 3, -1, -1, 1'b0);
    endtask

    task automatic test_ready_throttle();
        run_dump(1, 1, -1, -1, 1'b0);
        run_dump(2, 2, -1, -1, 1'b0);
    endtask

    task automatic test_halt_drop();
        run_dump(0, 2, 5, -1, 1'b0);
    endtask

    task automatic test_writeback_and_busy_start();
        run_dump(2, 2, -1, -1, 1'b1);
    endtask

    task automatic test_reset_mid_dump();
        run_dump(2, 1, -1, 10, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_held");
        rst = 1'b0;
        halted = 1'b0;
        @(posedge clk);
        #1;
        run_dump(0, 1, -1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_preload_passthru();
        test_basic_dump();
        test_ready_throttle();
        test_halt_drop();
        test_writeback_and_busy_start();
        test_reset_mid_dump();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
